// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load-extend encodings, link register
// index and the layout of the W pipeline register.
package mem_wb_stage_pkg;

    localparam logic [2:0] EXT_LW  = 3'b000;
    localparam logic [2:0] EXT_LBU = 3'b001;
    localparam logic [2:0] EXT_LB  = 3'b010;
    localparam logic [2:0] EXT_LHU = 3'b011;
    localparam logic [2:0] EXT_LH  = 3'b100;

    localparam logic [4:0] RA_REG = 5'd31;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
    } w_reg_t;

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/mem_wb_stage_dm_ext.sv
// Little-endian load extender: picks the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it; unknown encodings pass the word through.
module mem_wb_stage_dm_ext
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  extop,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (extop)
            EXT_LBU: data = {24'h0, byte_sel};
            EXT_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            EXT_LHU: data = {16'h0, half_sel};
            EXT_LH:  data = {{16{half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with the write-back datapath: GRF port selection,
// load extension, misalignment detection and a retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int LINK_OFS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [31:0]      m_instr,
    input  logic [31:0]      m_pc,
    input  logic [31:0]      m_alu_out,
    input  logic [31:0]      m_dm_rdata,
    output logic [31:0]      w_instr,
    output logic [31:0]      w_pc,
    input  logic [2:0]       w_dm_extop,
    input  logic             w_regwrite,
    input  logic             w_regdst,
    input  logic             w_memtoreg,
    input  logic             w_ifjal,
    input  logic             w_ifjalr,
    output logic             grf_we,
    output logic [4:0]       grf_waddr,
    output logic [31:0]      grf_wdata,
    output logic             w_misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    w_reg_t           w_d, w_q;
    logic [CNT_W-1:0] retire_cnt_d, retire_cnt_q;

    logic [1:0]  off;
    logic [31:0] ext_data;
    logic        is_lw, is_half;

    // Flush wins over stall so a squashed slot never keeps a stale instruction.
    always_comb begin
        w_d = w_q;
        if (flush) begin
            w_d = '0;
        end else if (!stall) begin
            w_d.valid = m_valid;
            w_d.instr = m_instr;
            w_d.pc    = m_pc;
            w_d.alu   = m_alu_out;
            w_d.rdata = m_dm_rdata;
        end
    end

    // An instruction retires only on the edge that moves it out of W.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (!flush && !stall && w_q.valid) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q          <= '0;
            retire_cnt_q <= '0;
        end else begin
            w_q          <= w_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign off = w_q.alu[1:0];

    mem_wb_stage_dm_ext u_dm_ext (
        .rdata (w_q.rdata),
        .off   (off),
        .extop (w_dm_extop),
        .data  (ext_data)
    );

    always_comb begin
        is_lw   = (w_dm_extop == EXT_LW);
        is_half = (w_dm_extop == EXT_LH) || (w_dm_extop == EXT_LHU);
        w_misalign = w_q.valid && w_memtoreg &&
                     ((is_lw && (off != 2'b00)) || (is_half && off[0]));
    end

    always_comb begin
        if (w_ifjal) begin
            grf_waddr = RA_REG;
        end else if (w_ifjalr) begin
            grf_waddr = instr_rd(w_q.instr);
        end else if (w_regdst) begin
            grf_waddr = instr_rt(w_q.instr);
        end else begin
            grf_waddr = instr_rd(w_q.instr);
        end
    end

    always_comb begin
        if (w_ifjal || w_ifjalr) begin
            grf_wdata = w_q.pc + 32'(LINK_OFS);
        end else if (w_memtoreg) begin
            grf_wdata = ext_data;
        end else begin
            grf_wdata = w_q.alu;
        end
    end

    // Misaligned loads still retire but must not corrupt the register file.
    assign grf_we = w_q.valid && w_regwrite && (grf_waddr != 5'd0) && !w_misalign;

    assign w_instr    = w_q.instr;
    assign w_pc       = w_q.pc;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table through a scoreboard queue,
// then hand sequences for stall/flush, counter wrap and mid-stream reset.
module tb_mem_wb_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, stall, flush, m_valid;
    logic [31:0]      m_instr, m_pc, m_alu_out, m_dm_rdata;
    logic [31:0]      w_instr, w_pc;
    logic [2:0]       w_dm_extop;
    logic             w_regwrite, w_regdst, w_memtoreg, w_ifjal, w_ifjalr;
    logic             grf_we, w_misalign;
    logic [4:0]       grf_waddr;
    logic [31:0]      grf_wdata;
    logic [CNT_W-1:0] retire_cnt;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(CNT_W), .LINK_OFS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_instr    (m_instr),
        .m_pc       (m_pc),
        .m_alu_out  (m_alu_out),
        .m_dm_rdata (m_dm_rdata),
        .w_instr    (w_instr),
        .w_pc       (w_pc),
        .w_dm_extop (w_dm_extop),
        .w_regwrite (w_regwrite),
        .w_regdst   (w_regdst),
        .w_memtoreg (w_memtoreg),
        .w_ifjal    (w_ifjal),
        .w_ifjalr   (w_ifjalr),
        .grf_we     (grf_we),
        .grf_waddr  (grf_waddr),
        .grf_wdata  (grf_wdata),
        .w_misalign (w_misalign),
        .retire_cnt (retire_cnt)
    );

    typedef struct {
        logic        valid;
        logic [31:0] instr, pc, alu, rdata;
        logic [2:0]  extop;
        logic        regwrite, regdst, memtoreg, ifjal, ifjalr;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];
    vec_t sb[$];
    vec_t e;

    int n_total = 0;
    int n_pass  = 0;
    logic [CNT_W-1:0] exp_cnt;

    function automatic vec_t mkv(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] rdata, input logic [2:0] extop,
                                 input logic rw, input logic rdst, input logic m2r, input logic jal,
                                 input logic jalr, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic mis);
        vec_t r;
        r.valid = v; r.instr = instr; r.pc = pc; r.alu = alu; r.rdata = rdata; r.extop = extop;
        r.regwrite = rw; r.regdst = rdst; r.memtoreg = m2r; r.ifjal = jal; r.ifjalr = jalr;
        r.exp_we = we; r.exp_waddr = wa; r.exp_wdata = wd; r.exp_mis = mis;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        m_valid = v.valid; m_instr = v.instr; m_pc = v.pc; m_alu_out = v.alu; m_dm_rdata = v.rdata;
        w_dm_extop = v.extop; w_regwrite = v.regwrite; w_regdst = v.regdst;
        w_memtoreg = v.memtoreg; w_ifjal = v.ifjal; w_ifjalr = v.ifjalr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //                valid instr         pc            alu           rdata         ext   rw rd m2r jal jr  we wa  wdata         mis
        vecs[0]  = mkv(1, 32'h8005_0000, 32'h0000_1000, 32'h0000_1003, 32'h80FF_1234, 3'b010, 1,1,1,0,0, 1, 5, 32'hFFFF_FF80, 0);
        vecs[1]  = mkv(1, 32'h9406_0000, 32'h0000_1004, 32'h0000_2002, 32'h8001_7FFF, 3'b011, 1,1,1,0,0, 1, 6, 32'h0000_8001, 0);
        vecs[2]  = mkv(1, 32'h8407_0000, 32'h0000_1008, 32'h0000_2002, 32'h8001_7FFF, 3'b100, 1,1,1,0,0, 1, 7, 32'hFFFF_8001, 0);
        vecs[3]  = mkv(1, 32'h0C00_0000, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 3'b000, 1,0,0,1,0, 1, 31, 32'h0000_3008, 0);
        vecs[4]  = mkv(1, 32'h0080_0009, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 3'b000, 1,0,0,0,1, 0, 0, 32'h0000_4008, 0);
        vecs[5]  = mkv(1, 32'h8C08_0000, 32'h0000_1014, 32'h0000_2002, 32'hDEAD_BEEF, 3'b000, 1,1,1,0,0, 0, 8, 32'hDEAD_BEEF, 1);
        vecs[6]  = mkv(1, 32'h0022_4821, 32'h0000_1018, 32'h1234_5678, 32'h0000_0000, 3'b000, 1,0,0,0,0, 1, 9, 32'h1234_5678, 0);
        vecs[7]  = mkv(1, 32'h900A_0000, 32'h0000_101C, 32'h0000_1001, 32'h0000_A500, 3'b001, 1,1,1,0,0, 1, 10, 32'h0000_00A5, 0);
        vecs[8]  = mkv(1, 32'h840B_0000, 32'h0000_1020, 32'h0000_1000, 32'h1234_8765, 3'b100, 1,1,1,0,0, 1, 11, 32'hFFFF_8765, 0);
        vecs[9]  = mkv(0, 32'h0022_4821, 32'h0000_1024, 32'h0000_0055, 32'h0000_0000, 3'b000, 1,0,0,0,0, 0, 9, 32'h0000_0055, 0);
        vecs[10] = mkv(1, 32'h800D_0000, 32'h0000_1028, 32'h0000_1001, 32'h0000_7F00, 3'b010, 1,1,1,0,0, 1, 13, 32'h0000_007F, 0);
        vecs[11] = mkv(1, 32'h800C_0000, 32'h0000_102C, 32'h0000_1003, 32'hCAFE_F00D, 3'b101, 1,1,1,0,0, 1, 12, 32'hCAFE_F00D, 0);
        vecs[12] = mkv(1, 32'h840E_0000, 32'h0000_1030, 32'h0000_1001, 32'h0000_1234, 3'b100, 1,1,1,0,0, 0, 14, 32'h0000_1234, 1);

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(mkv(0, 0, 0, 0, 0, 3'b000, 0,0,0,0,0, 0, 0, 0, 0));
        step();
        step();
        reset = 1'b0;
        chk("reset_w_instr", w_instr, 32'h0);
        chk("reset_w_pc", w_pc, 32'h0);
        chk("reset_grf_we", 32'(grf_we), 32'h0);
        chk("reset_grf_wdata", grf_wdata, 32'h0);
        chk("reset_retire_cnt", 32'(retire_cnt), 32'h0);
        exp_cnt = '0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            step();
            e = sb.pop_front();
            $display("vec %0d: instr=%08h we=%0b waddr=%0d wdata=%08h mis=%0b cnt=%0d",
                     i, w_instr, grf_we, grf_waddr, grf_wdata, w_misalign, retire_cnt);
            chk($sformatf("vec%0d_w_instr", i), w_instr, e.instr);
            chk($sformatf("vec%0d_w_pc", i), w_pc, e.pc);
            chk($sformatf("vec%0d_grf_we", i), 32'(grf_we), 32'(e.exp_we));
            chk($sformatf("vec%0d_grf_waddr", i), 32'(grf_waddr), 32'(e.exp_waddr));
            chk($sformatf("vec%0d_grf_wdata", i), grf_wdata, e.exp_wdata);
            chk($sformatf("vec%0d_misalign", i), 32'(w_misalign), 32'(e.exp_mis));
            chk($sformatf("vec%0d_retire_cnt", i), 32'(retire_cnt), 32'(exp_cnt));
            if (e.valid) exp_cnt = exp_cnt + 1'b1;
        end

        // Stall held 3 cycles on a valid addu
        drive(mkv(1, 32'h0022_4821, 32'h0000_5000, 32'h0000_0011, 0, 3'b000, 1,0,0,0,0, 1, 9, 32'h11, 0));
        step();
        $display("stall load: instr=%08h cnt=%0d", w_instr, retire_cnt);
        chk("stall_load_cnt", 32'(retire_cnt), 32'(exp_cnt));
        stall = 1'b1;
        m_instr = 32'hFFFF_FFFF; m_pc = 32'hFFFF_FFFF; m_alu_out = 32'hFFFF_FFFF; m_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            $display("stall cycle %0d: instr=%08h pc=%08h wdata=%08h cnt=%0d", k, w_instr, w_pc, grf_wdata, retire_cnt);
            chk("stall_hold_instr", w_instr, 32'h0022_4821);
            chk("stall_hold_pc", w_pc, 32'h0000_5000);
            chk("stall_hold_wdata", grf_wdata, 32'h0000_0011);
            chk("stall_hold_cnt", 32'(retire_cnt), 32'(exp_cnt));
        end
        stall = 1'b0; m_valid = 1'b0;
        step();
        exp_cnt = exp_cnt + 1'b1;
        $display("stall release: cnt=%0d", retire_cnt);
        chk("stall_release_cnt", 32'(retire_cnt), 32'(exp_cnt));
        step();
        chk("bubble_no_count", 32'(retire_cnt), 32'(exp_cnt));

        // stall and flush together load a bubble
        drive(mkv(1, 32'h0022_4821, 32'h0000_6000, 32'h0000_0022, 0, 3'b000, 1,0,0,0,0, 1, 9, 32'h22, 0));
        step();
        chk("pre_flush_instr", w_instr, 32'h0022_4821);
        stall = 1'b1; flush = 1'b1;
        step();
        $display("stall+flush: instr=%08h we=%0b cnt=%0d", w_instr, grf_we, retire_cnt);
        chk("flush_w_instr", w_instr, 32'h0);
        chk("flush_w_pc", w_pc, 32'h0);
        chk("flush_grf_we", 32'(grf_we), 32'h0);
        chk("flush_grf_wdata", grf_wdata, 32'h0);
        chk("flush_cnt", 32'(retire_cnt), 32'(exp_cnt));
        stall = 1'b0; flush = 1'b0;

        // Run valid instructions up to the counter wrap
        step();
        for (int k = 0; k < 40 && exp_cnt != {CNT_W{1'b1}}; k++) begin
            step();
            exp_cnt = exp_cnt + 1'b1;
        end
        chk("cnt_at_max", 32'(retire_cnt), 32'(exp_cnt));
        step();
        exp_cnt = exp_cnt + 1'b1;
        $display("wrap: cnt=%0d", retire_cnt);
        chk("cnt_wrap", 32'(retire_cnt), 32'h0);

        // Mid-run reset discards the in-flight instruction
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("mid reset: instr=%08h we=%0b cnt=%0d", w_instr, grf_we, retire_cnt);
        chk("midreset_w_instr", w_instr, 32'h0);
        chk("midreset_w_pc", w_pc, 32'h0);
        chk("midreset_grf_we", 32'(grf_we), 32'h0);
        chk("midreset_cnt", 32'(retire_cnt), 32'h0);
        drive(mkv(0, 32'hFFFF_FFFF, 0, 0, 0, 3'b000, 0,0,0,0,0, 0, 0, 0, 0));
        #1;
        chk("midreset_grf_wdata", grf_wdata, 32'h0);
        chk("midreset_grf_waddr", 32'(grf_waddr), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
